// File: rtl/rice_residual_ctrl_pkg.sv
// Shared definitions for the FLAC residual section sequencer and its helpers.
// Holds the state encoding, coding-method constants and the header sanity check.
package rice_pkg;

    localparam int RES_W_DEF = 32;

    localparam logic [1:0] RICE4     = 2'b00;
    localparam logic [1:0] RICE5     = 2'b01;
    localparam logic [3:0] ESC_PARAM = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_METHOD,
        ST_PORDER,
        ST_CONFIG,
        ST_RUN,
        ST_DONE,
        ST_ERROR
    } state_t;

    // A partition layout is usable only if every partition holds a whole number of
    // samples and the first one still has residuals left after the warm-up samples.
    function automatic logic porder_ok(input logic [15:0] bs, input logic [3:0] ord,
                                       input logic [3:0] porder);
        logic [15:0] mask;
        logic [15:0] ord_w;
        mask  = (16'd1 << porder) - 16'd1;
        ord_w = {12'd0, ord};
        return (bs > ord_w) && ((bs & mask) == 16'd0) &&
               ((porder == 4'd0) || ((bs >> porder) > ord_w));
    endfunction

endpackage

// File: rtl/rice_residual_ctrl_if.sv
// Bus between the residual sequencer, the subframe decoder, the Rice reader and the predictor.
// The slave modport is the sequencer's view; master is everything around it.
interface rice_residual_ctrl_if #(
    parameter int RES_W = 32,
    parameter int MSB_W = 16
);
    logic             iStart;
    logic [15:0]      iBlockSize;
    logic [3:0]       iPredictorOrder;
    logic             iData;
    logic             iValid;
    logic             oDataReq;
    logic             oRiceReset;
    logic             oRiceEnable;
    logic [15:0]      oBlockSize;
    logic [3:0]       oPredictorOrder;
    logic [3:0]       oPartitionOrder;
    logic             iRiceStrobe;
    logic [MSB_W-1:0] iMSB;
    logic [MSB_W-1:0] iLSB;
    logic [3:0]       iRiceParam;
    logic [RES_W-1:0] oResidual;
    logic             oResidualValid;
    logic             oBusy;
    logic             oDone;
    logic             oError;

    modport slave (
        input  iStart, iBlockSize, iPredictorOrder, iData, iValid,
               iRiceStrobe, iMSB, iLSB, iRiceParam,
        output oDataReq, oRiceReset, oRiceEnable, oBlockSize, oPredictorOrder,
               oPartitionOrder, oResidual, oResidualValid, oBusy, oDone, oError
    );

    modport master (
        output iStart, iBlockSize, iPredictorOrder, iData, iValid,
               iRiceStrobe, iMSB, iLSB, iRiceParam,
        input  oDataReq, oRiceReset, oRiceEnable, oBlockSize, oPredictorOrder,
               oPartitionOrder, oResidual, oResidualValid, oBusy, oDone, oError
    );
endinterface

// File: rtl/rice_residual_ctrl_unfold.sv
// Rice quotient/remainder/parameter to signed residual (zigzag unfold).
// Purely combinational so any decoder path can reuse it.
module rice_unfold #(
    parameter int RES_W = 32,
    parameter int MSB_W = 16
) (
    input  logic [MSB_W-1:0] msb,
    input  logic [MSB_W-1:0] lsb,
    input  logic [3:0]       param,
    output logic [RES_W-1:0] residual
);
    logic [RES_W-1:0] folded;

    always_comb begin
        folded   = (RES_W'(msb) << param) | RES_W'(lsb);
        residual = (folded >> 1) ^ {RES_W{folded[0]}};
    end
endmodule

// File: rtl/rice_residual_ctrl.sv
// Residual section sequencer: parses the residual header, then configures, resets
// and gates the Rice reader and turns its triples into signed residuals.
//
// state  | meaning
// IDLE   | waiting for start, reader held in reset
// METHOD | shifting the 2-bit coding method
// PORDER | shifting the 4-bit partition order, then validating the layout
// CONFIG | one cycle, config stable, reader still in reset, load residual count
// RUN    | reader active, unfolding one residual per strobe
// DONE   | one-cycle completion pulse
// ERROR  | sticky error, reader held in reset until the next start
module rice_residual_ctrl
    import rice_pkg::*;
#(
    parameter int RES_W = RES_W_DEF,
    parameter int MSB_W = 16
) (
    input logic                  iClock,
    input logic                  iReset,
    rice_residual_ctrl_if.slave  bus
);
    state_t           state;
    logic [1:0]       bit_cnt;
    logic             method_msb;
    logic [15:0]      remain;
    logic [15:0]      bs_q;
    logic [3:0]       ord_q;
    logic [3:0]       porder_q;
    logic [3:0]       porder_next;
    logic [RES_W-1:0] unfolded;

    rice_unfold #(.RES_W(RES_W), .MSB_W(MSB_W)) u_unfold (
        .msb      (bus.iMSB),
        .lsb      (bus.iLSB),
        .param    (bus.iRiceParam),
        .residual (unfolded)
    );

    assign porder_next         = {porder_q[2:0], bus.iData};
    assign bus.oBlockSize      = bs_q;
    assign bus.oPredictorOrder = ord_q;
    assign bus.oPartitionOrder = porder_q;
    // Enable follows iValid combinationally so it drops on the very edge that enters DONE.
    assign bus.oRiceEnable     = (state == ST_RUN) && bus.iValid;

    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            state              <= ST_IDLE;
            bit_cnt            <= '0;
            method_msb         <= 1'b0;
            remain             <= '0;
            bs_q               <= '0;
            ord_q              <= '0;
            porder_q           <= '0;
            bus.oDataReq       <= 1'b0;
            bus.oRiceReset     <= 1'b1;
            bus.oResidual      <= '0;
            bus.oResidualValid <= 1'b0;
            bus.oBusy          <= 1'b0;
            bus.oDone          <= 1'b0;
            bus.oError         <= 1'b0;
        end else begin
            bus.oResidualValid <= 1'b0;
            bus.oDone          <= 1'b0;
            case (state)
                ST_IDLE, ST_ERROR: begin
                    if (bus.iStart) begin
                        state        <= ST_METHOD;
                        bit_cnt      <= 2'd1;
                        bs_q         <= bus.iBlockSize;
                        ord_q        <= bus.iPredictorOrder;
                        bus.oError   <= 1'b0;
                        bus.oBusy    <= 1'b1;
                        bus.oDataReq <= 1'b1;
                    end
                end
                ST_METHOD: begin
                    if (bus.iValid) begin
                        method_msb <= bus.iData;
                        if (bit_cnt == 2'd0) begin
                            if ({method_msb, bus.iData} == RICE4) begin
                                state   <= ST_PORDER;
                                bit_cnt <= 2'd3;
                            end else begin
                                state        <= ST_ERROR;
                                bus.oError   <= 1'b1;
                                bus.oBusy    <= 1'b0;
                                bus.oDataReq <= 1'b0;
                            end
                        end else begin
                            bit_cnt <= bit_cnt - 2'd1;
                        end
                    end
                end
                ST_PORDER: begin
                    if (bus.iValid) begin
                        porder_q <= porder_next;
                        if (bit_cnt == 2'd0) begin
                            bus.oDataReq <= 1'b0;
                            if (porder_ok(bs_q, ord_q, porder_next)) begin
                                state <= ST_CONFIG;
                            end else begin
                                state      <= ST_ERROR;
                                bus.oError <= 1'b1;
                                bus.oBusy  <= 1'b0;
                            end
                        end else begin
                            bit_cnt <= bit_cnt - 2'd1;
                        end
                    end
                end
                ST_CONFIG: begin
                    state          <= ST_RUN;
                    remain         <= bs_q - {12'd0, ord_q};
                    bus.oRiceReset <= 1'b0;
                    bus.oDataReq   <= 1'b1;
                end
                ST_RUN: begin
                    if (bus.iRiceStrobe) begin
                        if (bus.iRiceParam == ESC_PARAM) begin
                            state          <= ST_ERROR;
                            bus.oError     <= 1'b1;
                            bus.oBusy      <= 1'b0;
                            bus.oDataReq   <= 1'b0;
                            bus.oRiceReset <= 1'b1;
                        end else begin
                            bus.oResidual      <= unfolded;
                            bus.oResidualValid <= 1'b1;
                            remain             <= remain - 16'd1;
                            if (remain == 16'd1) begin
                                state          <= ST_DONE;
                                bus.oDone      <= 1'b1;
                                bus.oRiceReset <= 1'b1;
                                bus.oDataReq   <= 1'b0;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    state     <= ST_IDLE;
                    bus.oBusy <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rice_residual_ctrl.sv
// Directed-plus-random bench for the residual section sequencer.
// Expected residuals come from an arithmetic zigzag model of each Rice triple.
module tb_rice_residual_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    rice_residual_ctrl_if #(.RES_W(32), .MSB_W(16)) bus ();

    rice_residual_ctrl #(.RES_W(32), .MSB_W(16)) dut (
        .iClock (clk),
        .iReset (rst),
        .bus    (bus)
    );

    int   vectors     = 0;
    int   miscompares = 0;
    logic stall       = 1'b0;
    int unsigned tm [64];
    int unsigned tl [64];
    int unsigned tp [64];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // residual = signed integer whose zigzag code is msb*2^p + lsb
    function automatic logic [31:0] model(input int unsigned msb, input int unsigned lsb,
                                          input int unsigned p);
        longint u;
        u = longint'(msb) * (longint'(1) << p) + longint'(lsb);
        if (u % 2 == 0) return 32'(u / 2);
        else            return 32'(-((u + 1) / 2));
    endfunction

    task automatic start(input logic [15:0] bs, input logic [3:0] ord);
        bus.iStart          = 1'b1;
        bus.iBlockSize      = bs;
        bus.iPredictorOrder = ord;
        bus.iValid          = 1'b0;
        cycle();
        bus.iStart = 1'b0;
        chk("start_busy", bus.oBusy, 1);
        chk("start_err_clr", bus.oError, 0);
        chk("start_dreq", bus.oDataReq, 1);
    endtask

    task automatic send_bits(input logic [3:0] val, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            if (stall && $urandom_range(0, 1) == 1) begin
                bus.iValid = 1'b0;
                bus.iData  = 1'($urandom_range(0, 1));
                cycle();
            end
            bus.iValid = 1'b1;
            bus.iData  = val[i];
            cycle();
        end
        bus.iValid = 1'b0;
    endtask

    task automatic reach_run(input logic [15:0] bs, input logic [3:0] ord, input logic [3:0] porder);
        start(bs, ord);
        send_bits(4'd0, 2);
        send_bits(porder, 4);
        chk("cfg_rice_reset", bus.oRiceReset, 1);
        chk("cfg_porder", bus.oPartitionOrder, porder);
        chk("cfg_blocksize", bus.oBlockSize, bs);
        chk("cfg_order", bus.oPredictorOrder, ord);
        chk("cfg_dreq", bus.oDataReq, 0);
        chk("cfg_error", bus.oError, 0);
        cycle();
        chk("run_rice_reset", bus.oRiceReset, 0);
        chk("run_dreq", bus.oDataReq, 1);
    endtask

    task automatic strobe(input int unsigned msb, input int unsigned lsb, input int unsigned p,
                          input logic last);
        logic v;
        v               = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        bus.iValid      = v;
        bus.iRiceStrobe = 1'b1;
        bus.iMSB        = 16'(msb);
        bus.iLSB        = 16'(lsb);
        bus.iRiceParam  = 4'(p);
        cycle();
        bus.iRiceStrobe = 1'b0;
        chk("res_valid", bus.oResidualValid, 1);
        chk("residual", bus.oResidual, model(msb, lsb, p));
        chk("done", bus.oDone, last);
        chk("rice_enable", bus.oRiceEnable, last ? 1'b0 : v);
        if (stall && $urandom_range(0, 1) == 1) begin
            bus.iValid = 1'($urandom_range(0, 1));
            cycle();
            chk("gap_valid", bus.oResidualValid, 0);
        end
    endtask

    task automatic run_body(input int total);
        for (int i = 0; i < total; i++) strobe(tm[i], tl[i], tp[i], i == total - 1);
        cycle();
        chk("end_busy", bus.oBusy, 0);
        chk("end_rice_reset", bus.oRiceReset, 1);
        chk("end_done", bus.oDone, 0);
    endtask

    initial begin
        bus.iStart = 0; bus.iBlockSize = 0; bus.iPredictorOrder = 0;
        bus.iData = 0; bus.iValid = 0; bus.iRiceStrobe = 0;
        bus.iMSB = 0; bus.iLSB = 0; bus.iRiceParam = 0;

        tm[0] = 1; tl[0] = 3; tp[0] = 2;
        tm[1] = 0; tl[1] = 2; tp[1] = 2;
        tm[2] = 0; tl[2] = 0; tp[2] = 0;
        for (int i = 3; i < 64; i++) begin
            tp[i] = $urandom_range(0, 14);
            tm[i] = $urandom_range(0, 300);
            tl[i] = (tp[i] == 0) ? 0 : $urandom_range(0, (1 << tp[i]) - 1);
        end

        #1 rst = 1'b1;
        #1;
        chk("rst_rice_reset", bus.oRiceReset, 1);
        chk("rst_busy", bus.oBusy, 0);
        chk("rst_done", bus.oDone, 0);
        chk("rst_error", bus.oError, 0);
        chk("rst_dreq", bus.oDataReq, 0);
        chk("rst_enable", bus.oRiceEnable, 0);
        chk("rst_valid", bus.oResidualValid, 0);
        chk("rst_residual", bus.oResidual, 0);
        chk("rst_porder", bus.oPartitionOrder, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        cycle();

        // Plain section, iValid held high, then replayed with iValid stalls.
        reach_run(16'd16, 4'd2, 4'd0);
        run_body(14);
        stall = 1'b1;
        reach_run(16'd16, 4'd2, 4'd0);
        run_body(14);
        stall = 1'b0;

        // Rice2 method header: error, reader never enabled, then recovery.
        start(16'd16, 4'd2);
        send_bits(4'd1, 2);
        chk("m01_error", bus.oError, 1);
        chk("m01_busy", bus.oBusy, 0);
        chk("m01_dreq", bus.oDataReq, 0);
        chk("m01_rice_reset", bus.oRiceReset, 1);
        for (int i = 0; i < 4; i++) begin
            bus.iValid = 1'b1;
            cycle();
            chk("m01_enable", bus.oRiceEnable, 0);
        end
        bus.iValid = 1'b0;
        reach_run(16'd8, 4'd1, 4'd1);
        run_body(7);

        // Partition layout failures.
        start(16'd12, 4'd2);
        send_bits(4'd0, 2);
        send_bits(4'd3, 4);
        chk("p3_bs12_error", bus.oError, 1);
        start(16'd16, 4'd2);
        send_bits(4'd0, 2);
        send_bits(4'd3, 4);
        chk("p3_bs16_error", bus.oError, 1);
        chk("p3_bs16_busy", bus.oBusy, 0);
        reach_run(16'd16, 4'd2, 4'd2);
        run_body(14);

        // Escape parameter mid-run, then a strobe outside RUN.
        reach_run(16'd16, 4'd2, 4'd0);
        strobe(tm[3], tl[3], tp[3], 1'b0);
        strobe(tm[4], tl[4], tp[4], 1'b0);
        bus.iValid      = 1'b1;
        bus.iRiceStrobe = 1'b1;
        bus.iRiceParam  = 4'hF;
        cycle();
        chk("esc_valid", bus.oResidualValid, 0);
        chk("esc_error", bus.oError, 1);
        chk("esc_busy", bus.oBusy, 0);
        chk("esc_enable", bus.oRiceEnable, 0);
        chk("esc_rice_reset", bus.oRiceReset, 1);
        bus.iRiceParam = 4'd2;
        cycle();
        bus.iRiceStrobe = 1'b0;
        chk("err_strobe_valid", bus.oResidualValid, 0);
        chk("err_strobe_sticky", bus.oError, 1);

        // Asynchronous reset after 5 residuals, then a fresh section.
        reach_run(16'd16, 4'd2, 4'd0);
        for (int i = 0; i < 5; i++) strobe(tm[i + 5], tl[i + 5], tp[i + 5], 1'b0);
        chk("pre_rst_rice_reset", bus.oRiceReset, 0);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_rice_reset", bus.oRiceReset, 1);
        chk("mid_rst_busy", bus.oBusy, 0);
        chk("mid_rst_valid", bus.oResidualValid, 0);
        chk("mid_rst_done", bus.oDone, 0);
        chk("mid_rst_dreq", bus.oDataReq, 0);
        chk("mid_rst_enable", bus.oRiceEnable, 0);
        rst = 1'b0;
        cycle();
        chk("post_rst_done", bus.oDone, 0);
        reach_run(16'd16, 4'd2, 4'd1);
        run_body(14);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
